// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter
//   Turns N_BTN debounced button levels into discrete events (press, release,
//   long-press), arbitrates them round-robin one per cycle into a small event
//   FIFO, and presents the FIFO head to the processor I/O side.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tick_en     1-cycle timebase strobe used for long-press timing
//   btn_level   debounced button levels, 1 = pressed
//   evt_valid   FIFO head holds an event
//   evt_ready   consumer accepts the head this cycle
//   evt_id      button index of the head event
//   evt_type    01 press, 10 release, 11 long-press
//   fifo_count  number of occupied FIFO entries
//   overflow    sticky flag: an event was lost
//   ovf_clr     clears overflow (a simultaneous drop wins)
//
// Handshake: an event transfers on every rising clk edge where evt_valid and
// evt_ready are both 1. While evt_valid=1 and evt_ready=0 the head
// (evt_id/evt_type) is held stable. evt_valid never depends combinationally
// on evt_ready; all head outputs come straight from registers.
// ---------------------------------------------------------------------------
module button_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int LONG_CNT   = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick_en,
  input  logic [N_BTN-1:0]              btn_level,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(N_BTN)-1:0]      evt_id,
  output logic [1:0]                    evt_type,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int IW = $clog2(N_BTN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam int EW = IW + 2;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_LONG    = 2'b11;

  // Per-button edge / hold tracking
  logic [N_BTN-1:0] r_prev_level;
  logic [HW-1:0]    r_hold_cnt [N_BTN];
  logic [N_BTN-1:0] r_long_done;

  // Pending event bits, one per button and event type
  logic [N_BTN-1:0] r_pend_press;
  logic [N_BTN-1:0] r_pend_long;
  logic [N_BTN-1:0] r_pend_rel;

  // Holds (last granted index + 1) mod N_BTN, so the reset value 0 makes
  // the first scan start at button 0.
  logic [IW-1:0]    r_scan_start;

  // Event FIFO with registered head
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_evt_valid;
  logic [EW-1:0]    r_head;
  logic             r_ovf;

  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_fall;
  logic [N_BTN-1:0] w_set_long;
  logic [N_BTN-1:0] w_clr_press;
  logic [N_BTN-1:0] w_clr_long;
  logic [N_BTN-1:0] w_clr_rel;
  logic             w_drop;

  logic             w_pop;
  logic             w_full;
  logic             w_can_accept;
  logic             w_grant_found;
  logic [IW-1:0]    w_grant_idx;
  logic [1:0]       w_grant_type;
  logic [IW-1:0]    w_scan_j;
  logic [EW-1:0]    w_push_data;
  logic [PW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic             w_head_valid_next;
  logic [EW-1:0]    w_head_data_next;

  // ---------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------
  assign w_rise = btn_level & ~r_prev_level;
  assign w_fall = ~btn_level & r_prev_level;

  // Long press fires on the tick that brings the hold count to LONG_CNT;
  // long_done blocks a second long event within the same press.
  always_comb begin
    w_set_long = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_set_long[i] = btn_level[i] & tick_en & ~r_long_done[i] &
                      (r_hold_cnt[i] == HW'(LONG_CNT - 1));
    end
  end

  // A set request on a bit that is already pending and not being granted
  // this cycle loses the event.
  assign w_drop = |((w_rise     & r_pend_press & ~w_clr_press) |
                    (w_set_long & r_pend_long  & ~w_clr_long)  |
                    (w_fall     & r_pend_rel   & ~w_clr_rel));

  // ---------------------------------------------------------------------
  // Round-robin arbiter: one grant per cycle, only if the FIFO can take it
  // ---------------------------------------------------------------------
  assign w_pop        = r_evt_valid & evt_ready;
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_can_accept = ~w_full | w_pop;

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_grant_type  = 2'b00;
    w_scan_j      = '0;
    w_clr_press   = '0;
    w_clr_long    = '0;
    w_clr_rel     = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (int'(r_scan_start) + k >= N_BTN) begin
        w_scan_j = IW'(int'(r_scan_start) + k - N_BTN);
      end else begin
        w_scan_j = IW'(int'(r_scan_start) + k);
      end
      if (w_can_accept && !w_grant_found) begin
        // Press before long before release keeps per-button order intact.
        if (r_pend_press[w_scan_j]) begin
          w_grant_found          = 1'b1;
          w_grant_idx            = w_scan_j;
          w_grant_type           = EVT_PRESS;
          w_clr_press[w_scan_j]  = 1'b1;
        end else if (r_pend_long[w_scan_j]) begin
          w_grant_found          = 1'b1;
          w_grant_idx            = w_scan_j;
          w_grant_type           = EVT_LONG;
          w_clr_long[w_scan_j]   = 1'b1;
        end else if (r_pend_rel[w_scan_j]) begin
          w_grant_found          = 1'b1;
          w_grant_idx            = w_scan_j;
          w_grant_type           = EVT_RELEASE;
          w_clr_rel[w_scan_j]    = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO next-head computation
  // ---------------------------------------------------------------------
  assign w_push_data  = {w_grant_idx, w_grant_type};
  assign w_rd_next    = r_rd_ptr + PW'(w_pop);
  assign w_count_next = r_count + CW'(w_grant_found) - CW'(w_pop);

  // The new head is the entry being written this cycle only when it lands
  // exactly at the next read position (FIFO empty, or one entry being popped).
  always_comb begin
    w_head_valid_next = (w_count_next != '0);
    w_head_data_next  = '0;
    if (w_head_valid_next) begin
      if (w_grant_found && (w_rd_next == r_wr_ptr)) begin
        w_head_data_next = w_push_data;
      end else begin
        w_head_data_next = r_mem[w_rd_next];
      end
    end
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_level <= '0;
      r_long_done  <= '0;
      r_pend_press <= '0;
      r_pend_long  <= '0;
      r_pend_rel   <= '0;
      r_scan_start <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_hold_cnt[i] <= '0;
      end
    end else begin
      r_prev_level <= btn_level;
      // Set wins over a same-cycle grant clear of the same bit.
      r_pend_press <= w_rise     | (r_pend_press & ~w_clr_press);
      r_pend_long  <= w_set_long | (r_pend_long  & ~w_clr_long);
      r_pend_rel   <= w_fall     | (r_pend_rel   & ~w_clr_rel);
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn_level[i]) begin
          r_hold_cnt[i]  <= '0;
          r_long_done[i] <= 1'b0;
        end else begin
          if (tick_en && (r_hold_cnt[i] != HW'(LONG_CNT))) begin
            r_hold_cnt[i] <= r_hold_cnt[i] + HW'(1);
          end
          if (w_set_long[i]) begin
            r_long_done[i] <= 1'b1;
          end
        end
      end
      if (w_grant_found) begin
        r_scan_start <= (w_grant_idx == IW'(N_BTN - 1)) ? '0 : w_grant_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_evt_valid <= 1'b0;
      r_head      <= '0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_grant_found) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_evt_valid <= w_head_valid_next;
      r_head      <= w_head_data_next;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign evt_valid  = r_evt_valid;
  assign evt_id     = r_head[EW-1:2];
  assign evt_type   = r_head[1:0];
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int LC = 4;
  localparam int D  = 4;
  localparam int IW = 2;
  localparam int EW = IW + 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_en = 1'b0;
  logic [N-1:0]  btn_level = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [IW-1:0] evt_id;
  logic [1:0]    evt_type;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          ovf_clr = 1'b0;

  always #5 clk = ~clk;

  button_event_arbiter #(.N_BTN(N), .LONG_CNT(LC), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_en    (tick_en),
    .btn_level  (btn_level),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_type   (evt_type),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Events are {id, type}. exp_q is the FIFO contents; exp_q[0] is the head.
  logic [EW-1:0] exp_q[$];
  bit m_prev[N];
  bit m_ld[N];
  bit m_pp[N];
  bit m_pl[N];
  bit m_pr[N];
  int m_hold[N];
  int m_last;
  bit m_ovf;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_ld[i] = 0; m_pp[i] = 0; m_pl[i] = 0; m_pr[i] = 0;
      m_hold[i] = 0;
    end
    m_last = -1;
    m_ovf  = 0;
    exp_q.delete();
  endfunction

  task automatic model_step();
    bit pop, acc, drop, lvl, sp, sl, sr, cp, cl, cr;
    int g;
    logic [1:0] gt;
    pop = (exp_q.size() > 0) && (evt_ready == 1'b1);
    acc = (exp_q.size() < D) || pop;
    g = -1;
    gt = 2'b00;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        int b;
        b = (m_last + 1 + k) % N;
        if (g < 0) begin
          if (m_pp[b])      begin g = b; gt = 2'b01; end
          else if (m_pl[b]) begin g = b; gt = 2'b11; end
          else if (m_pr[b]) begin g = b; gt = 2'b10; end
        end
      end
    end
    drop = 0;
    for (int b = 0; b < N; b++) begin
      lvl = (btn_level[b] == 1'b1);
      sp  = lvl && !m_prev[b];
      sr  = !lvl && m_prev[b];
      sl  = lvl && (tick_en == 1'b1) && !m_ld[b] && (m_hold[b] + 1 == LC);
      cp  = (g == b) && (gt == 2'b01);
      cl  = (g == b) && (gt == 2'b11);
      cr  = (g == b) && (gt == 2'b10);
      if (sp && m_pp[b] && !cp) drop = 1;
      if (sl && m_pl[b] && !cl) drop = 1;
      if (sr && m_pr[b] && !cr) drop = 1;
      m_pp[b] = sp || (m_pp[b] && !cp);
      m_pl[b] = sl || (m_pl[b] && !cl);
      m_pr[b] = sr || (m_pr[b] && !cr);
      if (!lvl) begin
        m_hold[b] = 0;
        m_ld[b]   = 0;
      end else if ((tick_en == 1'b1) && m_hold[b] < LC) begin
        m_hold[b] = m_hold[b] + 1;
      end
      if (sl) m_ld[b] = 1;
      m_prev[b] = lvl;
    end
    if (pop) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back({IW'(g), gt});
      m_last = g;
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr == 1'b1) m_ovf = 0;
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic cmp_out(input string name, input logic ev, input logic [IW-1:0] eid,
                         input logic [1:0] ety, input logic [2:0] ecnt, input logic eovf,
                         input bit chk_head);
    bit bad;
    bad = (evt_valid !== ev) || (fifo_count !== ecnt) || (overflow !== eovf) ||
          ((ev || chk_head) && ((evt_id !== eid) || (evt_type !== ety)));
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b id=%0d type=%b count=%0d ovf=%0b, expected valid=%0b id=%0d type=%b count=%0d ovf=%0b",
               name, evt_valid, evt_id, evt_type, fifo_count, overflow, ev, eid, ety, ecnt, eovf);
    end
  endtask

  task automatic check_model(input string name);
    logic ev;
    logic [IW-1:0] eid;
    logic [1:0] ety;
    ev  = (exp_q.size() > 0);
    eid = '0;
    ety = '0;
    if (ev) {eid, ety} = exp_q[0];
    cmp_out(name, ev, eid, ety, 3'(exp_q.size()), m_ovf, 1'b0);
  endtask

  task automatic check_seq(input string name, input logic [EW-1:0] got[$], input logic [EW-1:0] want[$]);
    bit bad;
    bad = (got.size() != want.size());
    if (!bad) begin
      for (int i = 0; i < want.size(); i++) if (got[i] !== want[i]) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got events %p, expected %p", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_level = '0;
    tick_en   = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    @(negedge clk);
    cmp_out("reset", 1'b0, '0, 2'b00, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Record the head if it will be consumed at the coming edge, then advance.
  logic [EW-1:0] obs[$];
  task automatic observe_cycle(input string name);
    if (evt_valid === 1'b1 && evt_ready === 1'b1) obs.push_back({evt_id, evt_type});
    tick_cycle();
    check_model(name);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          rst;
    logic [N-1:0]  btn;
    logic          ready;
    logic          exp_valid;
    logic [IW-1:0] exp_id;
    logic [1:0]    exp_type;
    logic [2:0]    exp_count;
  } vec_t;

  vec_t vecs[16];
  logic [EW-1:0] want[$];
  int ready_pct;

  initial begin
    // Single press/release of btn[2], then simultaneous btn[0]/btn[3].
    vecs[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[1]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[2]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b01, 3'd1};
    vecs[3]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 2'b10, 3'd1};
    vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[7]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[8]  = '{1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[9]  = '{1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, 2'b01, 3'd1};
    vecs[10] = '{1'b0, 4'b1001, 1'b1, 1'b1, 2'd3, 2'b01, 3'd1};
    vecs[11] = '{1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};
    vecs[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'b10, 3'd1};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'b10, 3'd1};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 3'd0};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) do_reset();
      btn_level = vecs[i].btn;
      evt_ready = vecs[i].ready;
      tick_en   = 1'b0;
      ovf_clr   = 1'b0;
      tick_cycle();
      cmp_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id,
              vecs[i].exp_type, vecs[i].exp_count, 1'b0, 1'b0);
    end

    // Long press on btn[1]: press, one long, release.
    do_reset();
    obs.delete();
    evt_ready = 1'b1;
    btn_level = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      tick_en = (i % 3 == 2);
      observe_cycle("long_hold");
    end
    tick_en   = 1'b0;
    btn_level = 4'b0000;
    for (int i = 0; i < 8; i++) observe_cycle("long_rel");
    want = {4'b0101, 4'b0111, 4'b0110};
    check_seq("long_seq", obs, want);

    // FIFO full with consumer stalled; extra events wait pending.
    do_reset();
    obs.delete();
    btn_level = 4'b1111;
    for (int i = 0; i < 6; i++) begin tick_cycle(); check_model("fill"); end
    btn_level = 4'b1100;
    for (int i = 0; i < 4; i++) begin tick_cycle(); check_model("stall"); end
    cmp_out("full_hold", 1'b1, 2'd0, 2'b01, 3'd4, 1'b0, 1'b0);
    evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) observe_cycle("drain");
    want = {4'b0001, 4'b0101, 4'b1001, 4'b1101, 4'b0010, 4'b0110};
    check_seq("drain_seq", obs, want);
    check_bit("drain_ovf", overflow, 1'b0);

    // Overflow: btn[1] press, release, press again while FIFO is full.
    do_reset();
    btn_level = 4'b1101;
    for (int i = 0; i < 4; i++) begin tick_cycle(); check_model("ovf_fill"); end
    btn_level = 4'b1100;
    for (int i = 0; i < 3; i++) begin tick_cycle(); check_model("ovf_fill2"); end
    cmp_out("ovf_full", 1'b1, 2'd0, 2'b01, 3'd4, 1'b0, 1'b0);
    btn_level = 4'b1110; tick_cycle(); check_model("ovf_p1");
    btn_level = 4'b1100; tick_cycle(); check_model("ovf_r1");
    btn_level = 4'b1110; tick_cycle(); check_model("ovf_p2");
    check_bit("ovf_set", overflow, 1'b1);
    ovf_clr = 1'b1; tick_cycle(); check_model("ovf_clr_cyc");
    ovf_clr = 1'b0; tick_cycle(); check_model("ovf_after");
    check_bit("ovf_cleared", overflow, 1'b0);
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin tick_cycle(); check_model("ovf_drain"); end

    // Asynchronous reset mid-drain with btn[2] held.
    do_reset();
    btn_level = 4'b1111;
    for (int i = 0; i < 5; i++) begin tick_cycle(); check_model("ar_fill"); end
    evt_ready = 1'b1;
    tick_cycle(); check_model("ar_drain");
    btn_level = 4'b0100;
    rst_n = 1'b0;
    #1;
    cmp_out("async_reset", 1'b0, '0, 2'b00, 3'd0, 1'b0, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    cmp_out("reset_hold", 1'b0, '0, 2'b00, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    obs.delete();
    for (int i = 0; i < 6; i++) observe_cycle("ar_after");
    want = {4'b1001};
    check_seq("ar_seq", obs, want);

    // Randomized traffic against the model.
    do_reset();
    ready_pct = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) ready_pct = (c % 1000 == 0) ? 80 : 25;
      if (c % 1500 == 700 || c % 1500 == 710) ready_pct = 0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) btn_level[b] = ~btn_level[b];
      end
      tick_en   = ($urandom_range(0, 2) == 0);
      evt_ready = ($urandom_range(0, 99) < ready_pct);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      tick_cycle();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
